// File: rtl/dmem_bus_adapter_if.sv
// Purpose: bundles the core-side load/store port and the word-bus port of the data-memory adapter.
// Latency: n/a (signal bundle only).
// Backpressure: bus_ready stalls the request phase; the core is held through stall.
// Ports: core side mem_read/mem_write/funct3/addr/wdata in, rdata/stall/fault out;
//        bus side bus_valid/bus_we/bus_addr/bus_be/bus_wdata out, bus_ready/bus_rvalid/bus_rdata in.
// Modports: master = adapter view, slave = core + memory environment view.
interface dmem_bus_adapter_if;
    // core side
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    // bus side
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        input  mem_read, mem_write, funct3, addr, wdata,
        output rdata, stall, fault,
        output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        output mem_read, mem_write, funct3, addr, wdata,
        input  rdata, stall, fault,
        input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_adapter.sv
// Purpose: turns core load/store requests into single word-bus transactions with lane steering and extension.
// Latency: store 2+ cycles of stall, load 3+ cycles; bus_ready/bus_rvalid waits add cycles, bounded by TIMEOUT.
// Backpressure: bus_ready holds the request phase; the core is frozen via stall until DONE.
// Ports: clk, reset (async active-low), dm (dmem_bus_adapter_if.master: core port + bus port).
module dmem_bus_adapter #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_bus_adapter_if.master     dm
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    // Abort when the counter would reach TIMEOUT, i.e. after TIMEOUT cycles in REQ+WAIT_RSP.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tmo_q, tmo_d;

    logic        req;
    logic        legal;
    logic [31:0] lane;
    logic [31:0] load_ext;
    logic [3:0]  be_w;
    logic [31:0] wdata_rep;

    assign req = dm.mem_read | dm.mem_write;

    always_comb begin
        legal = 1'b1;
        if (dm.funct3 == 3'd3 || dm.funct3 == 3'd6 || dm.funct3 == 3'd7) begin
            legal = 1'b0;
        end else if (dm.funct3[1:0] == 2'b01 && dm.addr[0]) begin
            legal = 1'b0;
        end else if (dm.funct3[1:0] == 2'b10 && dm.addr[1:0] != 2'b00) begin
            legal = 1'b0;
        end
    end

    // Bring the addressed lane down to bit 0, then extend by size/sign.
    assign lane = dm.bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_ext = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_ext = {24'd0, lane[7:0]};
            3'd5:    load_ext = {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be_w      = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_w      = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be_w      = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        tmo_d         = tmo_q;
        dm.stall      = 1'b0;
        dm.fault      = 1'b0;
        dm.rdata      = rdata_q;
        dm.bus_valid  = 1'b0;
        dm.bus_we     = 1'b0;
        dm.bus_addr   = 32'd0;
        dm.bus_be     = 4'd0;
        dm.bus_wdata  = 32'd0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (legal) begin
                        dm.stall = 1'b1;
                        state_d  = REQ;
                        addr_d   = dm.addr;
                        funct3_d = dm.funct3;
                        wdata_d  = dm.wdata;
                        we_d     = dm.mem_write;
                        cnt_d    = 8'd0;
                        tmo_d    = 1'b0;
                    end else begin
                        dm.fault = 1'b1;
                        dm.rdata = 32'd0;
                    end
                end
            end
            REQ: begin
                dm.stall     = 1'b1;
                dm.bus_valid = 1'b1;
                dm.bus_we    = we_q;
                dm.bus_addr  = {addr_q[31:2], 2'b00};
                dm.bus_be    = be_w;
                dm.bus_wdata = wdata_rep;
                cnt_d        = cnt_q + 8'd1;
                if (dm.bus_ready) begin
                    state_d = we_q ? DONE : WAIT_RSP;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            WAIT_RSP: begin
                dm.stall = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                if (dm.bus_rvalid) begin
                    rdata_d = load_ext;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                    rdata_d = 32'd0;
                end
            end
            DONE: begin
                // Core advances on this edge, so return to IDLE without looking at the request.
                dm.fault = tmo_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Request inputs may be live while reset is held; keep the core port quiet.
        if (!reset) begin
            dm.stall = 1'b0;
            dm.fault = 1'b0;
            dm.rdata = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_dmem_bus_adapter.sv
// Purpose: directed vector bench for dmem_bus_adapter plus timeout and mid-transaction reset sequences.
// Latency: n/a (testbench).
// Backpressure: bus_ready delay per vector; bus_rvalid one cycle after the read handshake.
module tb_dmem_bus_adapter;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_bus_adapter_if dm ();

    dmem_bus_adapter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .dm    (dm)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          dly;
        logic        exp_fault;
        int          exp_stall;
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'd0;
    vec_t        vecs [14];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                                input int dly, input logic ef, input int es, input logic [3:0] be,
                                input logic [31:0] ba, input logic [31:0] bw, input logic [31:0] er);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.brdata = brd;
        v.dly = dly; v.exp_fault = ef; v.exp_stall = es; v.exp_be = be;
        v.exp_baddr = ba; v.exp_bwdata = bw; v.exp_rdata = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_quiet();
        dm.mem_read   = 1'b0;
        dm.mem_write  = 1'b0;
        dm.funct3     = 3'd0;
        dm.addr       = 32'd0;
        dm.wdata      = 32'd0;
        dm.bus_ready  = 1'b0;
        dm.bus_rvalid = 1'b0;
        dm.bus_rdata  = 32'd0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        drive_quiet();
        #1;
        chk({tag, "_idle_stall"}, 32'(dm.stall), 32'd0);
        chk({tag, "_idle_fault"}, 32'(dm.fault), 32'd0);
        chk({tag, "_idle_valid"}, 32'(dm.bus_valid), 32'd0);
        chk({tag, "_idle_rdata"}, dm.rdata, last_rd);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        bit          hs, done, seen;
        int          stalls, hs_k;
        logic [3:0]  be;
        logic [31:0] ba, bw, rd;
        logic        bwe, flt;
        logic [31:0] exp_rd;
        hs = 0; done = 0; seen = 0; stalls = 0; hs_k = -10;
        be = 'x; ba = 'x; bw = 'x; bwe = 'x; flt = 'x; rd = 'x;
        @(negedge clk);
        dm.mem_read  = v.rd;
        dm.mem_write = v.wr;
        dm.funct3    = v.f3;
        dm.addr      = v.addr;
        dm.wdata     = v.wdata;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            dm.bus_ready  = (k >= v.dly);
            dm.bus_rvalid = hs && (k == hs_k + 1);
            dm.bus_rdata  = dm.bus_rvalid ? v.brdata : 32'h5A5A_5A5A;
            #1;
            if (dm.stall) stalls++;
            if (dm.bus_valid) seen = 1;
            if (dm.bus_valid && dm.bus_ready && !hs) begin
                hs = 1; hs_k = k;
                be = dm.bus_be; ba = dm.bus_addr; bw = dm.bus_wdata; bwe = dm.bus_we;
            end
            if (!dm.stall) begin
                done = 1; flt = dm.fault; rd = dm.rdata;
            end
        end
        chk({tag, "_completed"}, 32'(done), 32'd1);
        chk({tag, "_fault"}, 32'(flt), 32'(v.exp_fault));
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        if (v.exp_fault) begin
            chk({tag, "_bus_valid_seen"}, 32'(seen), 32'd0);
            exp_rd = 32'd0;
        end else begin
            chk({tag, "_bus_be"}, 32'(be), 32'(v.exp_be));
            chk({tag, "_bus_addr"}, ba, v.exp_baddr);
            chk({tag, "_bus_wdata"}, bw, v.exp_bwdata);
            chk({tag, "_bus_we"}, 32'(bwe), 32'(v.wr));
            exp_rd = v.wr ? last_rd : v.exp_rdata;
            if (!v.wr) last_rd = v.exp_rdata;
        end
        chk({tag, "_rdata"}, rd, exp_rd);
        check_idle(tag);
    endtask

    initial begin
        int stalls, vcnt;
        bit done;
        logic flt, bv;
        logic [31:0] rd;
        vec_t v;

        //          rd wr f3   addr          wdata          bus_rdata      dly fault stall be       baddr         bwdata         rdata
        vecs[0]  = mk(0, 1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2, 0, 3, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0);
        vecs[1]  = mk(1, 0, 3'd0, 32'h0000_0203, 32'h0,         32'h80FF_FF12, 0, 0, 3, 4'b1000, 32'h0000_0200, 32'h0,         32'hFFFF_FF80);
        vecs[2]  = mk(1, 0, 3'd4, 32'h0000_0203, 32'h0,         32'h80FF_FF12, 0, 0, 3, 4'b1000, 32'h0000_0200, 32'h0,         32'h0000_0080);
        vecs[3]  = mk(0, 1, 3'd1, 32'h0000_0102, 32'h0000_ABCD, 32'hCAFE_F00D, 0, 0, 2, 4'b1100, 32'h0000_0100, 32'hABCD_ABCD, 32'h0);
        vecs[4]  = mk(1, 0, 3'd2, 32'h0000_0101, 32'h0,         32'h1111_1111, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         32'h0);
        vecs[5]  = mk(1, 0, 3'd1, 32'h0000_0202, 32'h0,         32'h8001_1234, 2, 0, 4, 4'b1100, 32'h0000_0200, 32'h0,         32'hFFFF_8001);
        vecs[6]  = mk(1, 0, 3'd5, 32'h0000_0200, 32'h0,         32'h1234_9ABC, 0, 0, 3, 4'b0011, 32'h0000_0200, 32'h0,         32'h0000_9ABC);
        vecs[7]  = mk(0, 1, 3'd0, 32'h0000_0001, 32'h0000_00A5, 32'hCAFE_F00D, 0, 0, 2, 4'b0010, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0);
        vecs[8]  = mk(1, 0, 3'd2, 32'h0000_0300, 32'h0,         32'h1234_5678, 0, 0, 3, 4'b1111, 32'h0000_0300, 32'h0,         32'h1234_5678);
        vecs[9]  = mk(1, 0, 3'd0, 32'h0000_0201, 32'h0,         32'h0000_7F00, 3, 0, 5, 4'b0010, 32'h0000_0200, 32'h0,         32'h0000_007F);
        vecs[10] = mk(1, 0, 3'd3, 32'h0000_0000, 32'h0,         32'h2222_2222, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         32'h0);
        vecs[11] = mk(0, 1, 3'd1, 32'h0000_0101, 32'h0000_1234, 32'h3333_3333, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         32'h0);
        vecs[12] = mk(1, 1, 3'd2, 32'h0000_0104, 32'h1122_3344, 32'hCAFE_F00D, 0, 0, 2, 4'b1111, 32'h0000_0104, 32'h1122_3344, 32'h0);
        vecs[13] = mk(0, 1, 3'd7, 32'h0000_0000, 32'h0,         32'h4444_4444, 0, 1, 0, 4'b0000, 32'h0,         32'h0,         32'h0);

        // reset state
        reset = 1'b0;
        drive_quiet();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 32'(dm.stall), 32'd0);
        chk("rst_fault", 32'(dm.fault), 32'd0);
        chk("rst_valid", 32'(dm.bus_valid), 32'd0);
        chk("rst_be", 32'(dm.bus_be), 32'd0);
        chk("rst_addr", dm.bus_addr, 32'd0);
        chk("rst_rdata", dm.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // timeout: bus_ready never rises
        @(negedge clk);
        dm.mem_read = 1'b1; dm.funct3 = 3'd2; dm.addr = 32'h0000_0400;
        stalls = 0; vcnt = 0; done = 0; flt = 1'bx; bv = 1'bx; rd = 'x;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (dm.stall) stalls++;
            if (dm.bus_valid) vcnt++;
            if (!dm.stall) begin
                done = 1; flt = dm.fault; bv = dm.bus_valid; rd = dm.rdata;
            end
        end
        chk("tmo_completed", 32'(done), 32'd1);
        chk("tmo_stall_cycles", 32'(stalls), 32'(TMO + 1));
        chk("tmo_valid_cycles", 32'(vcnt), 32'(TMO));
        chk("tmo_fault", 32'(flt), 32'd1);
        chk("tmo_bus_valid", 32'(bv), 32'd0);
        chk("tmo_rdata", rd, 32'd0);
        last_rd = 32'd0;
        check_idle("tmo");

        // reset while waiting for the read response
        @(negedge clk);
        dm.mem_read = 1'b1; dm.funct3 = 3'd2; dm.addr = 32'h0000_0500; dm.bus_ready = 1'b1;
        @(negedge clk);   // REQ, handshake
        @(negedge clk);   // WAIT_RSP
        #1;
        chk("rstw_in_wait_stall", 32'(dm.stall), 32'd1);
        chk("rstw_in_wait_valid", 32'(dm.bus_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("rstw_stall", 32'(dm.stall), 32'd0);
        chk("rstw_fault", 32'(dm.fault), 32'd0);
        chk("rstw_valid", 32'(dm.bus_valid), 32'd0);
        chk("rstw_we", 32'(dm.bus_we), 32'd0);
        chk("rstw_be", 32'(dm.bus_be), 32'd0);
        chk("rstw_addr", dm.bus_addr, 32'd0);
        chk("rstw_wdata", dm.bus_wdata, 32'd0);
        chk("rstw_rdata", dm.rdata, 32'd0);
        @(negedge clk);
        drive_quiet();
        @(negedge clk);
        reset = 1'b1;
        dm.bus_rvalid = 1'b1; dm.bus_rdata = 32'h7777_7777;
        #1;
        chk("late_rsp_stall", 32'(dm.stall), 32'd0);
        chk("late_rsp_rdata", dm.rdata, 32'd0);
        @(negedge clk);
        dm.bus_rvalid = 1'b0;
        #1;
        chk("late_rsp_rdata2", dm.rdata, 32'd0);
        chk("late_rsp_fault", 32'(dm.fault), 32'd0);
        last_rd = 32'd0;

        v = mk(1, 0, 3'd2, 32'h0000_0504, 32'h0, 32'h0BAD_F00D, 0, 0, 3, 4'b1111, 32'h0000_0504, 32'h0, 32'h0BAD_F00D);
        run_txn(v, "post_rst_lw");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
